decrypt_loop_b: RTL
===================

DECRYPT_LOOP_B -- requirements
Module: decrypt_loop_b

Interface
REQ-001 Parameter KEY_BYTES, default 3, is the secret key length in bytes; the key byte index wraps modulo KEY_BYTES.
REQ-002 clock  input  1  single clock for all sequential logic.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  one-cycle pulse, normally driven by the upstream init loop's finished; sampled only in IDLE.
REQ-005 secret_key  input  8*KEY_BYTES  key; byte 0 = most significant byte.
REQ-006 q  input  8  S-memory read data; memory registers the address, output is unregistered.
REQ-007 address  output  8  S-memory address, registered.
REQ-008 data  output  8  S-memory write data, registered.
REQ-009 wren  output  1  S-memory write enable, registered, high only in the write states.
REQ-010 finished  output  1  high for exactly one cycle, in DONE.

Function
REQ-011 The block SHALL run the RC4 key schedule over S[0..255], which the upstream stage leaves initialised to S[i]=i:
- j = j + S[i] + key[i mod KEY_BYTES] (mod 256)
- then swap S[i] and S[j]
- for i = 0..255.
REQ-012 States SHALL be IDLE, READ_I, WAIT_I, READ_J, WAIT_J, WRITE_I, WRITE_J, ADVANCE, DONE.
REQ-013 IDLE: on start=1, go to READ_I with i=0, j=0, k=0 (key index).
REQ-014 READ_I: address=i, wren=0.
REQ-015 WAIT_I exit edge:
- latch si <= q
- j <= j + q + key byte k (8-bit wrap)
- address <= new j
- go to READ_J.
REQ-016 READ_J holds address=j; WAIT_J exit edge latches sj <= q.
REQ-017 WRITE_I: address=i, data=sj, wren=1.
REQ-018 WRITE_J: address=j, data=si, wren=1.
REQ-019 ADVANCE: wren=0; k wraps KEY_BYTES-1 -> 0 via counter, no divider.
REQ-020 ADVANCE exit: if i==255 go to DONE, else i <= i+1 and go to READ_I.
REQ-021 Cycle count: an iteration SHALL take 7 cycles; finished SHALL be high in the cycle after the 1792nd rising edge following the edge that samples start.
REQ-022 When i==j, the writes SHALL leave S[i] unchanged (both write si).
REQ-023 DONE SHALL assert finished for one cycle, then return to IDLE.
REQ-024 start outside IDLE SHALL be ignored.
REQ-025 All j and address arithmetic SHALL be 8-bit with silent wrap.

Reset
REQ-026 On reset, asynchronously:
- state=IDLE
- i=j=k=0; si=sj=0
- address=data=0, wren=0, finished=0.
REQ-027 Reset mid-run SHALL abort without further writes; S-memory contents are not restored; the next start restarts from i=0.

Configuration
REQ-028 With DECRYPT_LOOP_B_SKIP_SELF_SWAP_EN defined, when the new j equals i the WAIT_I exit SHALL go directly to ADVANCE, saving 4 cycles per such iteration, with identical final S-memory contents.
REQ-029 Without DECRYPT_LOOP_B_SKIP_SELF_SWAP_EN, every iteration SHALL take 7 cycles (REQ-021).

Structure
REQ-030 Shared package decrypt_pkg SHALL hold:
- the state enum
- S_SIZE=256
- default KEY_BYTES=3.
REQ-031 No sub-module is needed; an optional key_byte_sel sub-module may select the key byte from k.

Verification
REQ-032 Identity S, key 24'h000001:
- i=0 and i=1 swap nothing (j=0, j=1)
- i=2 gives j=4, so afterwards S[2]=4 and S[4]=2
- final S is compared against a software RC4 KSA model.
REQ-033 Key 24'h000000, macro undefined: finished after exactly 1792 edges. Macro defined: exactly 1784 edges (self-swaps only at i=0 and i=1).
REQ-034 Reset asserted during WRITE_I at i=100:
- wren falls immediately, outputs 0, state IDLE
- a subsequent start yields a correct full schedule after re-initialising S.
REQ-035 start pulsed at i=50 during the run SHALL be ignored: no restart, finished still at edge 1792.
REQ-036 KEY_BYTES=4, key 32'h01020304: k SHALL wrap 3 -> 0 at i=3 -> 4, and the final S SHALL match the model.
REQ-037 finished SHALL be high for exactly 1 cycle, and wren SHALL never be high outside WRITE_I and WRITE_J (assertion).

Source files
------------

// File: rtl/decrypt_pkg.sv
// Shared types and constants for the RC4 key-schedule (decrypt) loop.
package decrypt_pkg;

   localparam int unsigned S_SIZE            = 256;
   localparam int unsigned DEFAULT_KEY_BYTES = 3;

   typedef enum logic [3:0] {
      StIdle,
      StReadI,
      StWaitI,
      StReadJ,
      StWaitJ,
      StWriteI,
      StWriteJ,
      StAdvance,
      StDone
   } state_e;

   // Width of the key byte index; at least one bit even for a single-byte key.
   function automatic int unsigned key_idx_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/decrypt_loop_b_key_byte_sel.sv
// Selects key byte k from a packed key whose byte 0 is the most significant byte.
module decrypt_loop_b_key_byte_sel
   import decrypt_pkg::*;
#(
   parameter int unsigned KEY_BYTES = DEFAULT_KEY_BYTES
) (
   input  logic [8*KEY_BYTES-1:0]          secret_key_i,
   input  logic [key_idx_w(KEY_BYTES)-1:0] k_i,
   output logic [7:0]                      key_byte_o
);

   localparam int unsigned KeyIdxW = key_idx_w(KEY_BYTES);

   always_comb begin
      key_byte_o = 8'h00;
      for (int b = 0; b < int'(KEY_BYTES); b++) begin
         if (k_i == KeyIdxW'(b)) begin
            key_byte_o = secret_key_i[8*(int'(KEY_BYTES)-1-b) +: 8];
         end
      end
   end

endmodule

// File: rtl/decrypt_loop_b.sv
// RC4 key schedule over a 256-byte S-memory with a registered-address read port.
// Optional: DECRYPT_LOOP_B_SKIP_SELF_SWAP_EN skips the read/write of S[j] when j == i.
module decrypt_loop_b
   import decrypt_pkg::*;
#(
   parameter int unsigned KEY_BYTES = DEFAULT_KEY_BYTES
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   start,
   input  logic [8*KEY_BYTES-1:0] secret_key,
   input  logic [7:0]             q,
   output logic [7:0]             address,
   output logic [7:0]             data,
   output logic                   wren,
   output logic                   finished
);

   localparam int unsigned KeyIdxW = key_idx_w(KEY_BYTES);

   state_e             state_q, state_d;
   logic [7:0]         i_q, i_d;
   logic [7:0]         j_q, j_d;
   logic [KeyIdxW-1:0] k_q, k_d;
   logic [7:0]         si_q, si_d;
   logic [7:0]         sj_q, sj_d;
   logic [7:0]         address_q, address_d;
   logic [7:0]         data_q, data_d;
   logic               wren_q, wren_d;
   logic               finished_q, finished_d;

   logic [7:0]         key_byte;
   logic [7:0]         j_new;

   decrypt_loop_b_key_byte_sel #(
      .KEY_BYTES (KEY_BYTES)
   ) u_key_byte_sel (
      .secret_key_i (secret_key),
      .k_i          (k_q),
      .key_byte_o   (key_byte)
   );

   assign j_new = j_q + q + key_byte;

   // Outputs are registered: each state's address/data/wren is loaded on the edge entering it.
   always_comb begin
      state_d    = state_q;
      i_d        = i_q;
      j_d        = j_q;
      k_d        = k_q;
      si_d       = si_q;
      sj_d       = sj_q;
      address_d  = address_q;
      data_d     = data_q;
      wren_d     = 1'b0;
      finished_d = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d   = StReadI;
               i_d       = 8'h00;
               j_d       = 8'h00;
               k_d       = '0;
               address_d = 8'h00;
            end
         end
         StReadI: state_d = StWaitI;
         StWaitI: begin
            si_d = q;
            j_d  = j_new;
`ifdef DECRYPT_LOOP_B_SKIP_SELF_SWAP_EN
            if (j_new == i_q) begin
               state_d = StAdvance;
            end else begin
               address_d = j_new;
               state_d   = StReadJ;
            end
`else
            address_d = j_new;
            state_d   = StReadJ;
`endif
         end
         StReadJ: state_d = StWaitJ;
         StWaitJ: begin
            // When j == i the S[j] read returns S[i], so both writes carry si.
            sj_d      = q;
            address_d = i_q;
            data_d    = q;
            wren_d    = 1'b1;
            state_d   = StWriteI;
         end
         StWriteI: begin
            address_d = j_q;
            data_d    = si_q;
            wren_d    = 1'b1;
            state_d   = StWriteJ;
         end
         StWriteJ: state_d = StAdvance;
         StAdvance: begin
            k_d = (k_q == KeyIdxW'(KEY_BYTES - 1)) ? '0 : k_q + 1'b1;
            if (i_q == 8'(S_SIZE - 1)) begin
               finished_d = 1'b1;
               state_d    = StDone;
            end else begin
               i_d       = i_q + 8'h01;
               address_d = i_q + 8'h01;
               state_d   = StReadI;
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q    <= StIdle;
         i_q        <= 8'h00;
         j_q        <= 8'h00;
         k_q        <= '0;
         si_q       <= 8'h00;
         sj_q       <= 8'h00;
         address_q  <= 8'h00;
         data_q     <= 8'h00;
         wren_q     <= 1'b0;
         finished_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         i_q        <= i_d;
         j_q        <= j_d;
         k_q        <= k_d;
         si_q       <= si_d;
         sj_q       <= sj_d;
         address_q  <= address_d;
         data_q     <= data_d;
         wren_q     <= wren_d;
         finished_q <= finished_d;
      end
   end

   assign address  = address_q;
   assign data     = data_q;
   assign wren     = wren_q;
   assign finished = finished_q;

endmodule
